// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_regfile
//  Purpose  : I2C target with an 8-bit register file and an auto-increment
//             pointer. The bus is oversampled through synchronizers on clk.
//  Options  : define I2C_GENERAL_CALL_EN to also ACK the general-call write
//             address 7'h00.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h05,
    parameter int         DEPTH       = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     RESET_N,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe,
    output logic [6:0]               ADRESS_OUT,
    output logic [7:0]               DATA_OUT,
    output logic                     wr_valid,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic                     busy
);

    localparam int         c_PW    = $clog2(DEPTH);
    localparam logic [8:0] c_DEPTH = 9'(DEPTH);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;

    state_t                 r_state;
    logic [7:0]             r_shift;
    logic [3:0]             r_bitcnt;
    logic                   r_rw;
    logic                   r_gcall;
    logic                   r_mack;
    logic [c_PW-1:0]        r_ptr;
    logic [7:0]             r_regs [DEPTH];

    logic                   w_scl;
    logic                   w_sda;
    logic                   w_scl_rise;
    logic                   w_scl_fall;
    logic                   w_start;
    logic                   w_stop;
    logic                   w_byte_done;
    logic                   w_shift_en;
    logic                   w_ptr_ok;
    logic                   w_addr_hit;
    logic                   w_gc_hit;
    logic [c_PW-1:0]        w_ptr_inc;

    assign w_scl       = r_scl_sync[SYNC_STAGES-1];
    assign w_sda       = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise  =  w_scl & ~r_scl_prev;
    assign w_scl_fall  = ~w_scl &  r_scl_prev;
    // Both lines are delayed equally, so SDA edges seen with SCL high on
    // both samples are genuine START/STOP conditions.
    assign w_start     = w_scl & r_scl_prev &  r_sda_prev & ~w_sda;
    assign w_stop      = w_scl & r_scl_prev & ~r_sda_prev &  w_sda;
    assign w_byte_done = w_scl_fall && (r_bitcnt == 4'd8);
    assign w_shift_en  = w_scl_rise && (r_bitcnt != 4'd8);
    assign w_ptr_ok    = {1'b0, r_shift} < c_DEPTH;
    assign w_addr_hit  = (r_shift[7:1] == SLAVE_ADDR);
    assign w_ptr_inc   = r_ptr + c_PW'(1);

`ifdef I2C_GENERAL_CALL_EN
    assign w_gc_hit    = (r_shift == 8'h00);
`else
    assign w_gc_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= IDLE;
            r_shift    <= 8'h00;
            r_bitcnt   <= 4'd0;
            r_rw       <= 1'b0;
            r_gcall    <= 1'b0;
            r_mack     <= 1'b0;
            r_ptr      <= '0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            ADRESS_OUT <= 7'h00;
            DATA_OUT   <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            wr_valid <= 1'b0;
            if (w_start) begin
                r_state  <= ADDR;
                r_bitcnt <= 4'd0;
                r_gcall  <= 1'b0;
                sda_oe   <= 1'b0;
                busy     <= 1'b1;
            end else if (w_stop) begin
                r_state  <= IDLE;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (r_state)
                    ADDR: begin
                        if (w_shift_en) begin
                            r_shift  <= {r_shift[6:0], w_sda};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_byte_done) begin
                            if (w_addr_hit || w_gc_hit) begin
                                sda_oe     <= 1'b1;
                                ADRESS_OUT <= r_shift[7:1];
                                r_rw       <= r_shift[0];
                                r_gcall    <= w_gc_hit;
                                r_state    <= ADDR_ACK;
                            end else begin
                                r_state    <= WAIT_STOP;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_bitcnt <= 4'd0;
                            if (r_rw) begin
                                r_shift <= r_regs[r_ptr];
                                sda_oe  <= ~r_regs[r_ptr][7];
                                r_state <= RDATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                r_state <= r_gcall ? WDATA : PTR;
                            end
                        end
                    end

                    PTR: begin
                        if (w_shift_en) begin
                            r_shift  <= {r_shift[6:0], w_sda};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_byte_done) begin
                            if (w_ptr_ok) begin
                                r_ptr   <= r_shift[c_PW-1:0];
                                sda_oe  <= 1'b1;
                                r_state <= PTR_ACK;
                            end else begin
                                r_state <= WAIT_STOP;
                            end
                        end
                    end

                    PTR_ACK, WDATA_ACK: begin
                        if (w_scl_fall) begin
                            sda_oe   <= 1'b0;
                            r_bitcnt <= 4'd0;
                            r_state  <= WDATA;
                        end
                    end

                    WDATA: begin
                        if (w_shift_en) begin
                            r_shift  <= {r_shift[6:0], w_sda};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_byte_done) begin
                            wr_valid <= 1'b1;
                            DATA_OUT <= r_shift;
                            sda_oe   <= 1'b1;
                            r_state  <= WDATA_ACK;
                            if (r_gcall) begin
                                wr_addr <= '0;
                            end else begin
                                r_regs[r_ptr] <= r_shift;
                                wr_addr       <= r_ptr;
                                r_ptr         <= w_ptr_inc;
                            end
                        end
                    end

                    RDATA: begin
                        if (w_shift_en) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                r_state <= RDATA_ACK;
                            end else if (r_bitcnt != 4'd0) begin
                                sda_oe  <= ~r_shift[6];
                                r_shift <= {r_shift[6:0], 1'b0};
                            end
                        end
                    end

                    RDATA_ACK: begin
                        if (w_scl_rise) begin
                            r_mack <= ~w_sda;
                        end else if (w_scl_fall) begin
                            // Pointer advances past every byte sent, even the NACKed last one.
                            r_ptr    <= w_ptr_inc;
                            r_bitcnt <= 4'd0;
                            if (r_mack) begin
                                r_shift <= r_regs[w_ptr_inc];
                                sda_oe  <= ~r_regs[w_ptr_inc][7];
                                r_state <= RDATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                r_state <= WAIT_STOP;
                            end
                        end
                    end

                    IDLE, WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end

                    default: begin
                        sda_oe  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
